gh_fifo_sync_thr: RTL and testbench

Single-clock synchronous FIFO with parametrised data width and depth. It is the single-clock counterpart to our 16-deep async FIFO, used where producer and consumer share one clock domain.
Adds an occupancy count, programmable almost-full and almost-empty thresholds, a synchronous flush, and write-through-on-full when a read happens in the same cycle.
Storage is an inferred RAM of 2**add_width words with a registered read port.

---
 rtl/gh_fifo_sync_thr.sv | 141 ++++++++++++++
 tb/tb_gh_fifo_sync_thr.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/gh_fifo_sync_thr.sv
// Single-clock FIFO with occupancy count, almost-full/empty thresholds, synchronous flush
// and write-through on full. Optional sticky ovf/unf error flags: define GH_FIFO_ERR_FLAGS_EN.
module gh_fifo_sync_thr #(
    parameter int unsigned data_width = 8,
    parameter int unsigned add_width  = 4,
    parameter int unsigned af_level   = 12,
    parameter int unsigned ae_level   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  srst,
    input  logic                  WR,
    input  logic                  RD,
    input  logic [data_width-1:0] D,
    output logic [data_width-1:0] Q,
    output logic [add_width:0]    count,
    output logic                  empty,
    output logic                  full,
    output logic                  almost_empty,
    output logic                  almost_full
`ifdef GH_FIFO_ERR_FLAGS_EN
    ,
    output logic                  ovf,
    output logic                  unf
`endif
);

    localparam int unsigned DEPTH = 1 << add_width;
    localparam int unsigned CW    = add_width + 1;
    localparam int unsigned AW    = add_width;

    // Reject illegal configurations at elaboration time
    if (data_width < 1) begin : g_bad_data_width
        $fatal(1, "gh_fifo_sync_thr: data_width must be >= 1");
    end
    if (add_width < 2 || add_width > 12) begin : g_bad_add_width
        $fatal(1, "gh_fifo_sync_thr: add_width must be in 2..12");
    end
    if (af_level < 1 || af_level > DEPTH) begin : g_bad_af_level
        $fatal(1, "gh_fifo_sync_thr: af_level must be in 1..DEPTH");
    end
    if (ae_level >= DEPTH) begin : g_bad_ae_level
        $fatal(1, "gh_fifo_sync_thr: ae_level must be in 0..DEPTH-1");
    end

    logic [data_width-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [data_width-1:0] q_q, q_d;
    logic                  rd_ok, rd_acc, wr_acc;

    assign empty        = (count_q == '0);
    assign full         = (count_q == CW'(DEPTH));
    assign almost_empty = (count_q <= CW'(ae_level));
    assign almost_full  = (count_q >= CW'(af_level));
    assign count        = count_q;
    assign Q            = q_q;

    // Accept decode; a write on full is allowed only alongside an accepted read
    always_comb begin
        rd_ok  = RD & ~empty;
        rd_acc = rd_ok & ~srst;
        wr_acc = WR & (~full | rd_ok) & ~srst;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        q_d      = q_q;
        if (srst) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            q_d      = '0;
        end else begin
            if (wr_acc) begin
                wr_ptr_d = wr_ptr_q + AW'(1);
            end
            if (rd_acc) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
                q_d      = mem_q[rd_ptr_q];
            end
            case ({wr_acc, rd_acc})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            q_q      <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            q_q      <= q_d;
        end
    end

    // Storage is not reset so it maps onto plain RAM
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= D;
        end
    end

`ifdef GH_FIFO_ERR_FLAGS_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // Sticky error flags, cleared only by a reset or flush
    always_comb begin
        ovf_d = ovf_q | (WR & full & ~rd_ok);
        unf_d = unf_q | (RD & empty);
        if (srst) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
            unf_q <= unf_d;
        end
    end

    assign ovf = ovf_q;
    assign unf = unf_q;
`endif

endmodule

// File: tb/tb_gh_fifo_sync_thr.sv
// Bench for gh_fifo_sync_thr: queue-based reference model with a scoreboard on Q,
// plus a second instance (16-bit, depth 8) exercised with random wrap-around traffic.
module tb_gh_fifo_sync_thr;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int          DEPTH = 16;
    localparam int          AF    = 12;
    localparam int          AE    = 2;
    localparam int          DEPTH2 = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          srst, wr, rd;
    logic [DW-1:0] d, q;
    logic [AW:0]   count;
    logic          empty, full, almost_empty, almost_full;

    logic          srst2, wr2, rd2;
    logic [15:0]   d2, q2;
    logic [3:0]    count2;
    logic          empty2, full2, ae2, af2;
`ifdef GH_FIFO_ERR_FLAGS_EN
    logic          ovf, unf, ovf2, unf2;
`endif

    always #5 clk = ~clk;

    gh_fifo_sync_thr #(.data_width(DW), .add_width(AW), .af_level(AF), .ae_level(AE)) u_dut (
        .clk(clk), .rst_n(rst_n), .srst(srst), .WR(wr), .RD(rd), .D(d), .Q(q),
        .count(count), .empty(empty), .full(full),
        .almost_empty(almost_empty), .almost_full(almost_full)
`ifdef GH_FIFO_ERR_FLAGS_EN
        , .ovf(ovf), .unf(unf)
`endif
    );

    gh_fifo_sync_thr #(.data_width(16), .add_width(3), .af_level(6), .ae_level(1)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .srst(srst2), .WR(wr2), .RD(rd2), .D(d2), .Q(q2),
        .count(count2), .empty(empty2), .full(full2),
        .almost_empty(ae2), .almost_full(af2)
`ifdef GH_FIFO_ERR_FLAGS_EN
        , .ovf(ovf2), .unf(unf2)
`endif
    );

    int checks = 0;
    int errors = 0;

    logic [DW-1:0] model[$];
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] m_q = '0;
    logic          flush_pend = 1'b0;
    logic          chk_en = 1'b0;
    logic          m_ovf = 1'b0, m_unf = 1'b0;
    logic          rd_seen;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", name, act, expv, $time);
        end
    endfunction

    // A read actually taken by the DUT at this edge
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) rd_seen <= 1'b0;
        else        rd_seen <= rd & ~empty & ~srst;
    end

    // Monitor: pops expected read data when the DUT takes a read, checks state every cycle
    always @(negedge clk) begin
        if (chk_en) begin
            if (flush_pend) begin
                m_q = '0;
                flush_pend = 1'b0;
            end
            if (rd_seen) begin
                if (exp_q.size() == 0) chk("unexpected_read", 32'(1), 32'(0));
                else m_q = exp_q.pop_front();
            end
            chk("Q", 32'(q), 32'(m_q));
            chk("count", 32'(count), 32'(model.size()));
            chk("empty", 32'(empty), 32'(model.size() == 0));
            chk("full", 32'(full), 32'(model.size() == DEPTH));
            chk("almost_empty", 32'(almost_empty), 32'(model.size() <= AE));
            chk("almost_full", 32'(almost_full), 32'(model.size() >= AF));
`ifdef GH_FIFO_ERR_FLAGS_EN
            chk("ovf", 32'(ovf), 32'(m_ovf));
            chk("unf", 32'(unf), 32'(m_unf));
`endif
        end
    end

    // One clock of stimulus on the main instance; the model decides what is accepted
    task automatic cycle(input logic w, input logic r, input logic [DW-1:0] dv, input logic sr);
        bit ra, wa;
        wr = w; rd = r; d = dv; srst = sr;
        if (sr) begin
            model.delete();
            exp_q.delete();
            flush_pend = 1'b1;
            m_ovf = 1'b0;
            m_unf = 1'b0;
        end else begin
            ra = r && model.size() > 0;
            wa = w && (model.size() < DEPTH || ra);
            if (w && model.size() == DEPTH && !ra) m_ovf = 1'b1;
            if (r && model.size() == 0) m_unf = 1'b1;
            if (ra) exp_q.push_back(model.pop_front());
            if (wa) model.push_back(dv);
        end
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic do_reset();
        wr = 1'b0; rd = 1'b0; srst = 1'b0;
        wr2 = 1'b0; rd2 = 1'b0; srst2 = 1'b0;
        rst_n = 1'b0;
        model.delete();
        exp_q.delete();
        flush_pend = 1'b1;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    logic [15:0] s_model[$];

    // One clock on the second instance, checked in-line against its own queue model
    task automatic s_cycle(input logic w, input logic r, input logic [15:0] dv, input logic sr);
        bit ra, wa;
        logic [15:0] expd;
        wr2 = w; rd2 = r; d2 = dv; srst2 = sr;
        ra = 1'b0;
        expd = '0;
        if (sr) begin
            s_model.delete();
        end else begin
            ra = r && s_model.size() > 0;
            wa = w && (s_model.size() < DEPTH2 || ra);
            if (ra) expd = s_model.pop_front();
            if (wa) s_model.push_back(dv);
        end
        @(posedge clk);
        @(negedge clk);
        chk("count2", 32'(count2), 32'(s_model.size()));
        chk("full2", 32'(full2), 32'(s_model.size() == DEPTH2));
        if (ra) chk("Q2", 32'(q2), 32'(expd));
        if (sr) chk("Q2_flush", 32'(q2), 32'(0));
        #1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        d = '0; d2 = '0;
        chk_en = 1'b1;
        do_reset();

        // Fill to full, then one write that must be ignored
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        cycle(1'b1, 1'b0, 8'hEE, 1'b0);
        // Drain in order
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Write-through on full
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, DW'(i), 1'b0);
        cycle(1'b1, 1'b1, 8'hAA, 1'b0);
        for (int i = 0; i < 16; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);

        // Simultaneous WR/RD on empty: only the write lands
        cycle(1'b1, 1'b1, 8'h55, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Flush wins over a same-cycle write; no stale data afterwards
        for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, DW'(8'h80 + i), 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b1, 1'b0, 8'h99, 1'b1);
        cycle(1'b1, 1'b0, 8'h3C, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Async reset mid-transfer
        for (int i = 0; i < 3; i++) cycle(1'b1, 1'b1, DW'(8'h40 + i), 1'b0);
        do_reset();
        cycle(1'b1, 1'b0, 8'h77, 1'b0);
        cycle(1'b0, 1'b1, 8'h00, 1'b0);
        cycle(1'b0, 1'b0, 8'h00, 1'b0);

        // Random traffic with occasional flushes
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 50,
                  DW'($urandom), $urandom_range(0, 99) < 2);
        end
        for (int i = 0; i < 17; i++) cycle(1'b0, 1'b1, 8'h00, 1'b0);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        // Second configuration: random wrap-around traffic
        for (int i = 0; i < 80; i++) begin
            s_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 50,
                    16'($urandom), 1'b0);
        end
        s_cycle(1'b0, 1'b0, 16'h0, 1'b1);
`ifdef GH_FIFO_ERR_FLAGS_EN
        chk("unf2_cleared", 32'(unf2), 32'(0));
        s_cycle(1'b0, 1'b1, 16'h0, 1'b0);
        chk("unf2_set", 32'(unf2), 32'(1));
        s_cycle(1'b1, 1'b0, 16'h1234, 1'b0);
        s_cycle(1'b0, 1'b1, 16'h0, 1'b0);
        chk("unf2_sticky", 32'(unf2), 32'(1));
        s_cycle(1'b0, 1'b0, 16'h0, 1'b1);
        chk("unf2_srst", 32'(unf2), 32'(0));
`else
        s_cycle(1'b1, 1'b0, 16'h1234, 1'b0);
        s_cycle(1'b0, 1'b1, 16'h0, 1'b0);
`endif

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
